icache_ctrl: RTL
================

Name: icache_ctrl

Overview:
- Instruction-cache controller between the fetch stage, the direct-mapped 128x64 icache data/tag array and the instruction memory bus.
- Splits the fetch PC into index/tag and drives the array's read port.
- Detects misses, issues one tagged BUS_LOAD at a time, and writes the returned line into the array through its write port.
- Forwards fill data to fetch in the fill cycle.

Parameters:
- ADDR_BITS, 64, fetch/memory address width.
- DATA_SIZE, 64, line/instruction-pair width; must equal the array's DATA_SIZE.
- MEM_TAG_BITS, 4, memory transaction tag width; tag 0 means none/rejected.
- CNT_BITS, 32, miss counter width.

Ports:
- clock, input, 1, sole clock, posedge.
- reset, input, 1, synchronous, active-high.
- proc2Icache_addr, input, ADDR_BITS, fetch PC; bits [2:0] ignored.
- Icache_data_out, output, DATA_SIZE, instruction line to fetch.
- Icache_valid_out, output, 1, Icache_data_out valid this cycle.
- current_index, output, ICACHE_IDX_BITS, array read index.
- current_tag, output, ICACHE_TAG_BITS, array read tag.
- cachemem_data, input, DATA_SIZE, array read data.
- cachemem_valid, input, 1, array hit (valid and tag match).
- data_write_enable, output, 1, array write strobe.
- wr_idx, output, ICACHE_IDX_BITS, array write index.
- wr_tag, output, ICACHE_TAG_BITS, array write tag.
- wr_data, output, DATA_SIZE, array write data.
- proc2Imem_command, output, 2, BUS_NONE/BUS_LOAD.
- proc2Imem_addr, output, ADDR_BITS, line address: {miss_tag, miss_idx, 3'b0}.
- Imem2proc_response, input, MEM_TAG_BITS, nonzero = request accepted with this tag.
- Imem2proc_data, input, DATA_SIZE, returned line.
- Imem2proc_tag, input, MEM_TAG_BITS, tag of returning data; 0 = none.
- miss_count, output, CNT_BITS, saturating miss counter.

Behaviour:
- Decode, combinational:
  - current_index = addr[ICACHE_IDX_BITS+2:3].
  - current_tag = addr[ADDR_BITS-1:ICACHE_IDX_BITS+3].
- Hit:
  - Icache_valid_out = cachemem_valid, Icache_data_out = cachemem_data, same cycle.
  - Zero-latency; no bus traffic.
- State register: IDLE, REQ, WAIT. Registers: miss_idx, miss_tag, pend_tag.
- Reset value: state IDLE, pend_tag 0, miss_count 0.
- Outputs under reset: proc2Imem_command BUS_NONE, data_write_enable 0, Icache_valid_out 0.
- IDLE:
  - On !cachemem_valid: latch miss_idx/miss_tag from current PC and go to REQ.
  - On that transition, increment miss_count (saturate at all-ones).
- REQ:
  - proc2Imem_command = BUS_LOAD, addr from miss regs.
  - If Imem2proc_response != 0: pend_tag <= response; go to WAIT.
  - Else (rejected) retry next cycle. Before retrying:
    - If the PC moved and now hits: go to IDLE.
    - If the PC moved and still misses: reload miss regs with the new PC (no counter increment) and stay in REQ.
- WAIT:
  - Command BUS_NONE.
  - When Imem2proc_tag == pend_tag, with pend_tag != 0:
    - data_write_enable = 1; wr_idx/wr_tag = miss regs; wr_data = Imem2proc_data.
    - pend_tag <= 0; go to IDLE.
  - A WAIT is never abandoned. A PC change completes the fill for the old line.
- Fill forwarding: in the fill cycle, if the current PC index/tag equals the miss regs:
  - Icache_valid_out = 1, Icache_data_out = Imem2proc_data.
- Imem2proc_tag that is nonzero but not equal to pend_tag (e.g. dcache traffic): ignored.
- Acceptance and data for the same tag never occur in one cycle. Only a registered pend_tag is compared.
- Reset mid-miss:
  - Return to IDLE, clear pend_tag.
  - A late response with the old tag is ignored; no write occurs.
- Write port writes only in the fill cycle. The array updates at that clock edge, so the next-cycle lookup hits.

Decomposition:
- Shared header sys_defs.vh holds:
  - BUS_NONE/BUS_LOAD/BUS_STORE encodings.
  - ICACHE_LINES, ICACHE_IDX_BITS, ICACHE_TAG_BITS.
  - State encodings ICC_IDLE/ICC_REQ/ICC_WAIT.
- Single module; no sub-module. The array is instantiated beside it at the icache top, not inside it.

Test Plan:
- Reset, then PC=0x100 with the array empty -> Icache_valid_out=0 and BUS_LOAD addr 0x100 from the cycle after reset; miss_count=1.
- Response=3 while in REQ, then Imem2proc_tag=3 with data 0xDEADBEEF_CAFEF00D two cycles later -> data_write_enable=1, wr_idx=0x20, Icache_valid_out=1 with that data the same cycle; next cycle a hit with no bus command.
- Response=0 for 4 cycles -> BUS_LOAD held constant every cycle. Then PC changes to 0x208 (miss) -> proc2Imem_addr becomes 0x208; miss_count unchanged.
- In WAIT with pend_tag=5, PC changes to a hitting address; tag 5 returns -> old line written, valid_out follows the hit, no forwarding.
- Foreign tag 7 arrives while pend_tag=5 -> no write. Reset asserted in WAIT, then tag 5 arrives -> no write, state IDLE.
- Force 2^CNT_BITS-1 misses (small CNT_BITS build, e.g. 3) -> miss_count saturates at 7.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction-cache controller: bus command encodings,
// icache geometry and controller state encodings.
package icache_ctrl_pkg;

  localparam int unsigned ICACHE_LINES    = 128;
  localparam int unsigned ICACHE_IDX_BITS = $clog2(ICACHE_LINES);
  localparam int unsigned ICACHE_OFS_BITS = 3;
  localparam int unsigned ICACHE_TAG_BITS = 64 - ICACHE_IDX_BITS - ICACHE_OFS_BITS;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic [1:0] {
    ICC_IDLE = 2'h0,
    ICC_REQ  = 2'h1,
    ICC_WAIT = 2'h2
  } icc_state_t;

endpackage

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: PC decode, hit pass-through, single outstanding
// line fill from instruction memory with fill-cycle forwarding and a miss counter.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 64,
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned MEM_TAG_BITS = 4,
  parameter int unsigned CNT_BITS     = 32,
  localparam int unsigned TAG_BITS    = ADDR_BITS - ICACHE_IDX_BITS - ICACHE_OFS_BITS
) (
  input  logic                       clock,
  input  logic                       reset,

  input  logic [ADDR_BITS-1:0]       proc2Icache_addr,
  output logic [DATA_SIZE-1:0]       Icache_data_out,
  output logic                       Icache_valid_out,

  output logic [ICACHE_IDX_BITS-1:0] current_index,
  output logic [TAG_BITS-1:0]        current_tag,
  input  logic [DATA_SIZE-1:0]       cachemem_data,
  input  logic                       cachemem_valid,

  output logic                       data_write_enable,
  output logic [ICACHE_IDX_BITS-1:0] wr_idx,
  output logic [TAG_BITS-1:0]        wr_tag,
  output logic [DATA_SIZE-1:0]       wr_data,

  output logic [1:0]                 proc2Imem_command,
  output logic [ADDR_BITS-1:0]       proc2Imem_addr,
  input  logic [MEM_TAG_BITS-1:0]    Imem2proc_response,
  input  logic [DATA_SIZE-1:0]       Imem2proc_data,
  input  logic [MEM_TAG_BITS-1:0]    Imem2proc_tag,

  output logic [CNT_BITS-1:0]        miss_count
);

  icc_state_t                 state;
  bus_command_t               cmd_q;
  logic [ICACHE_IDX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]        miss_tag;
  logic [MEM_TAG_BITS-1:0]    pend_tag;
  logic [CNT_BITS-1:0]        count_q;

  logic fill;
  logic pc_on_miss_line;

  assign current_index = proc2Icache_addr[ICACHE_IDX_BITS+ICACHE_OFS_BITS-1:ICACHE_OFS_BITS];
  assign current_tag   = proc2Icache_addr[ADDR_BITS-1:ICACHE_IDX_BITS+ICACHE_OFS_BITS];

  // Only the registered pend_tag is matched; tag 0 never completes a fill.
  assign fill = !reset && (state == ICC_WAIT) && (pend_tag != '0) &&
                (Imem2proc_tag == pend_tag);
  assign pc_on_miss_line = (current_index == miss_idx) && (current_tag == miss_tag);

  always_comb begin
    Icache_valid_out = 1'b0;
    Icache_data_out  = cachemem_data;
    if (!reset) begin
      if (fill && pc_on_miss_line) begin
        Icache_valid_out = 1'b1;
        Icache_data_out  = Imem2proc_data;
      end else begin
        Icache_valid_out = cachemem_valid;
      end
    end
  end

  assign data_write_enable = fill;
  assign wr_idx            = miss_idx;
  assign wr_tag            = miss_tag;
  assign wr_data           = Imem2proc_data;

  // The command register can lag reset by a cycle, so it is masked while reset is high.
  assign proc2Imem_command = reset ? BUS_NONE : cmd_q;
  assign proc2Imem_addr    = {miss_tag, miss_idx, {ICACHE_OFS_BITS{1'b0}}};
  assign miss_count        = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ICC_IDLE;
      cmd_q    <= BUS_NONE;
      pend_tag <= '0;
      count_q  <= '0;
    end else begin
      unique case (state)
        ICC_IDLE: begin
          if (!cachemem_valid) begin
            miss_idx <= current_index;
            miss_tag <= current_tag;
            if (count_q != '1) count_q <= count_q + CNT_BITS'(1);
            state    <= ICC_REQ;
            cmd_q    <= BUS_LOAD;
          end
        end
        ICC_REQ: begin
          if (Imem2proc_response != '0) begin
            pend_tag <= Imem2proc_response;
            state    <= ICC_WAIT;
            cmd_q    <= BUS_NONE;
          end else if (cachemem_valid) begin
            state <= ICC_IDLE;
            cmd_q <= BUS_NONE;
          end else begin
            // Retry follows the PC: the request is re-aimed at whatever line now misses.
            miss_idx <= current_index;
            miss_tag <= current_tag;
          end
        end
        ICC_WAIT: begin
          if (fill) begin
            pend_tag <= '0;
            state    <= ICC_IDLE;
          end
        end
        default: begin
          state <= ICC_IDLE;
          cmd_q <= BUS_NONE;
        end
      endcase
    end
  end

endmodule
